// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
// Transmit buffer sitting between the CPU bus and a UART transmitter.
// The CPU queues bytes into a FIFO without having to poll the transmitter.
// A small sequencer hands the bytes to the transmitter one at a time.
// An interrupt pulse is raised once the queue has fully drained.
//
// Ports
//   i_clk        system clock
//   i_reset      synchronous active-high reset
//   i_addr       0 = data/level register, 1 = status/control register
//   i_dat        bus write data
//   o_dat        bus read data (combinational)
//                  addr0 = count
//                  addr1 = {4'b0, overflow, full, empty, tx busy}
//   i_we, i_cyc  bus write enable / cycle valid
//   o_int        one-cycle pulse when the last queued byte finishes transmitting
//   o_tx_dat     byte presented to the transmitter (registered)
//   o_tx_we      transmitter write strobe, one cycle per byte
//   o_tx_cyc     transmitter cycle valid (same as o_tx_we)
//   i_tx_status  transmitter status; bit0 = busy, other bits unused
module uart_tx_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_addr,
    input  logic [7:0] i_dat,
    output logic [7:0] o_dat,
    input  logic       i_we,
    input  logic       i_cyc,
    output logic       o_int,
    output logic [7:0] o_tx_dat,
    output logic       o_tx_we,
    output logic       o_tx_cyc,
    input  logic [7:0] i_tx_status
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_BUSY,
        ST_WAIT_DONE
    } state_t;

    state_t                r_state;
    logic [7:0]            r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  r_overflow;
    logic                  r_int;
    logic                  r_tx_we;
    logic [7:0]            r_tx_dat;

    logic w_empty;
    logic w_full;
    logic w_push;
    logic w_push_ok;
    logic w_pop;
    logic w_clr;
    logic w_busy;
    logic w_unused_status;

    assign w_empty   = (r_count == '0);
    // count never exceeds DEPTH, so its MSB alone marks the full state
    assign w_full    = r_count[DEPTH_LOG2];
    assign w_push    = i_cyc & i_we & ~i_addr;
    // full is judged on the current count, so a pop in the same cycle
    // does not make room for this push
    assign w_push_ok = w_push & ~w_full;
    assign w_pop     = (r_state == ST_IDLE) & ~w_empty;
    assign w_clr     = i_cyc & i_we & i_addr & i_dat[0];
    assign w_busy    = i_tx_status[0];
    assign w_unused_status = ^i_tx_status[7:1];

    always_comb begin
        if (i_addr) begin
            o_dat = {4'b0, r_overflow, w_full, w_empty, w_busy};
        end else begin
            o_dat = 8'(r_count);
        end
    end

    // Storage: written only, no reset; the read happens at pop time in the sequencer
    always_ff @(posedge i_clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_dat;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_push & w_full) begin
                r_overflow <= 1'b1;
            end else if (w_clr) begin
                r_overflow <= 1'b0;
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sequencer. The transmitter reports busy only a couple of cycles after
    // its write, so WAIT_BUSY holds off until busy is seen before WAIT_DONE
    // starts watching for it to fall again.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state  <= ST_IDLE;
            r_rd_ptr <= '0;
            r_int    <= 1'b0;
            r_tx_we  <= 1'b0;
            r_tx_dat <= 8'h00;
        end else begin
            r_int   <= 1'b0;
            r_tx_we <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        r_state  <= ST_ISSUE;
                        r_tx_we  <= 1'b1;
                        r_tx_dat <= r_mem[r_rd_ptr];
                        r_rd_ptr <= r_rd_ptr + 1'b1;
                    end
                end
                ST_ISSUE: begin
                    r_state <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    if (w_busy) begin
                        r_state <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (!w_busy) begin
                        r_state <= ST_IDLE;
                        // a push landing this same cycle still counts as drained
                        r_int   <= w_empty;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_int    = r_int;
    assign o_tx_we  = r_tx_we;
    assign o_tx_cyc = r_tx_we;
    assign o_tx_dat = r_tx_dat;

endmodule
